// File: rtl/sr_trace_buffer_pkg.sv
// ============================================================================
// sr_trace_buffer_pkg : trace entry layout, default depth and packing helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package sr_trace_buffer_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int WA_W    = 5;
  localparam int WD_W    = 32;

  localparam int WD_OFS    = 0;
  localparam int WA_OFS    = WD_OFS + WD_W;
  localparam int WE_OFS    = WA_OFS + WA_W;
  localparam int INSTR_OFS = WE_OFS + 1;
  localparam int PC_OFS    = INSTR_OFS + INSTR_W;
  localparam int ENTRY_W   = PC_OFS + PC_W;

  localparam int DEFAULT_DEPTH = 16;

  // Field order mirrors the offsets above (first field is the MSB).
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               we;
    logic [WA_W-1:0]    wa;
    logic [WD_W-1:0]    wd;
  } trace_entry_t;

  function automatic trace_entry_t make_entry(
    input logic [PC_W-1:0]    pc,
    input logic [INSTR_W-1:0] instr,
    input logic               we,
    input logic [WA_W-1:0]    wa,
    input logic [WD_W-1:0]    wd
  );
    trace_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.we    = we && (wa != '0);
    e.wa    = wa;
    e.wd    = wd;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_trace_fifo.sv
// ============================================================================
// sr_trace_fifo : generic first-word-fall-through FIFO with entry count
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/sr_trace_buffer.sv
// ============================================================================
// sr_trace_buffer : instruction-trace capture with FIFO, drop/instr counters.
// Optional capture limit enabled by macro SR_TRACE_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_trace_buffer
  import sr_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int AW      = 4,
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trace_en,
  input  logic                clr,
  input  logic [PC_W-1:0]     cpu_pc,
  input  logic [INSTR_W-1:0]  cpu_instr,
  input  logic                cpu_rf_we,
  input  logic [WA_W-1:0]     cpu_rf_wa,
  input  logic [WD_W-1:0]     cpu_rf_wd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_we,
  output logic [WA_W-1:0]     out_wa,
  output logic [WD_W-1:0]     out_wd,
  output logic                overflow,
  output logic [CNTW-1:0]     drop_cnt,
  output logic [CNTW-1:0]     instr_cnt,
  output logic                timeout
);

  if (DEPTH < 2 || (1 << AW) != DEPTH || TIMEOUT < 1) begin : g_cfg_check
    $error("sr_trace_buffer: invalid DEPTH/AW/TIMEOUT combination");
  end

  trace_entry_t       entry;
  logic [ENTRY_W-1:0] head;
  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               capture;
  logic               pop;
  logic               drop;

  assign entry   = make_entry(cpu_pc, cpu_instr, cpu_rf_we, cpu_rf_wa, cpu_rf_wd);
  assign capture = trace_en && !timeout;
  assign pop     = out_ready && !fifo_empty;
  assign drop    = capture && fifo_full && !pop;

  sr_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (capture),
    .pop   (out_ready),
    .din   (entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_pc    = head[PC_OFS +: PC_W];
  assign out_instr = head[INSTR_OFS +: INSTR_W];
  assign out_we    = head[WE_OFS];
  assign out_wa    = head[WA_OFS +: WA_W];
  assign out_wd    = head[WD_OFS +: WD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      instr_cnt <= '0;
    end else if (clr) begin
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      if (capture) instr_cnt <= instr_cnt + CNTW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

`ifdef SR_TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cap_cycles;

  // Counting stops once the limit is hit, so the counter never exceeds TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cycles <= '0;
      timeout    <= 1'b0;
    end else if (clr) begin
      cap_cycles <= '0;
      timeout    <= 1'b0;
    end else if (capture) begin
      cap_cycles <= cap_cycles + TW'(1);
      if (cap_cycles == TW'(TIMEOUT - 1)) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_trace_buffer.sv
// ============================================================================
// tb_sr_trace_buffer : vector table, corner sequences and random run vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sr_trace_buffer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int CNTW    = 16;
  localparam int TIMEOUT = 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trace_en;
  logic        clr;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_rf_we;
  logic [4:0]  cpu_rf_wa;
  logic [31:0] cpu_rf_wd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_we;
  logic [4:0]  out_wa;
  logic [31:0] out_wd;
  logic        overflow;
  logic [CNTW-1:0] drop_cnt;
  logic [CNTW-1:0] instr_cnt;
  logic        timeout;

  always #5 clk = ~clk;

  sr_trace_buffer #(
    .DEPTH(DEPTH), .AW(AW), .CNTW(CNTW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .clr(clr),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_rf_we(cpu_rf_we),
    .cpu_rf_wa(cpu_rf_wa), .cpu_rf_wd(cpu_rf_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_we(out_we),
    .out_wa(out_wa), .out_wd(out_wd),
    .overflow(overflow), .drop_cnt(drop_cnt), .instr_cnt(instr_cnt),
    .timeout(timeout)
  );

  typedef struct {
    bit [31:0] pc;
    bit [31:0] instr;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
  } ent_t;

  typedef struct {
    bit        en;
    bit [31:0] pc;
    bit [31:0] instr;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        rdy;
    bit        ev;
    bit [31:0] epc;
    bit        ewe;
    bit [4:0]  ewa;
    bit [31:0] ewd;
    bit [15:0] eicnt;
  } vec_t;

  // Reference model state: queue contents plus counters.
  ent_t        q[$];
  int unsigned m_icnt;
  int unsigned m_drop;
  bit          m_ovf;
  bit          m_to;
  int unsigned m_tcnt;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_icnt = 0; m_drop = 0; m_ovf = 0; m_to = 0; m_tcnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit c, input ent_t e, input bit rdy);
    bit pop;
    bit cap;
    if (c) begin
      model_reset();
    end else begin
      pop = rdy && (q.size() > 0);
`ifdef SR_TRACE_TIMEOUT_EN
      cap = en && !m_to;
      if (cap) begin
        m_tcnt++;
        if (m_tcnt == TIMEOUT) m_to = 1;
      end
`else
      cap = en;
`endif
      if (pop) void'(q.pop_front());
      if (cap) begin
        m_icnt = (m_icnt + 1) % (1 << CNTW);
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop < (1 << CNTW) - 1) m_drop++;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check({tag, ".pc"},    out_pc,    q[0].pc);
      check({tag, ".instr"}, out_instr, q[0].instr);
      check({tag, ".we"},    out_we,    q[0].we);
      check({tag, ".wa"},    out_wa,    q[0].wa);
      check({tag, ".wd"},    out_wd,    q[0].wd);
    end
    check({tag, ".overflow"},  overflow,  m_ovf);
    check({tag, ".drop_cnt"},  drop_cnt,  m_drop);
    check({tag, ".instr_cnt"}, instr_cnt, m_icnt);
    check({tag, ".timeout"},   timeout,   m_to);
  endtask

  task automatic step(input string tag, input bit en, input bit c, input logic [31:0] pc,
                      input logic [31:0] instr, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input bit rdy);
    ent_t e;
    trace_en = en; clr = c; cpu_pc = pc; cpu_instr = instr;
    cpu_rf_we = we; cpu_rf_wa = wa; cpu_rf_wd = wd; out_ready = rdy;
    e = '{pc, instr, we && (wa != 5'd0), wa, wd};
    @(posedge clk);
    model_edge(en, c, e, rdy);
    #1;
    compare_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 32'h00, 32'h00200513, 1, 5'd10, 32'd2,   1, 1, 32'h00, 1, 5'd10, 32'd2, 16'd1};
    tbl[1] = '{0, 32'h00, 32'h0,        0, 5'd0,  32'd0,   1, 0, 32'h00, 0, 5'd0,  32'd0, 16'd1};
    tbl[2] = '{1, 32'h04, 32'h00500013, 1, 5'd0,  32'd5,   0, 1, 32'h04, 0, 5'd0,  32'd5, 16'd2};
    tbl[3] = '{0, 32'h00, 32'h0,        0, 5'd0,  32'd0,   0, 1, 32'h04, 0, 5'd0,  32'd5, 16'd2};
    tbl[4] = '{0, 32'h00, 32'h0,        0, 5'd0,  32'd0,   1, 0, 32'h00, 0, 5'd0,  32'd0, 16'd2};
    tbl[5] = '{1, 32'h08, 32'h00a00593, 0, 5'd11, 32'h1234, 0, 1, 32'h08, 0, 5'd11, 32'h1234, 16'd3};
    tbl[6] = '{1, 32'h0C, 32'h00000fb3, 1, 5'd31, 32'hFFFFFFFF, 1, 1, 32'h0C, 1, 5'd31, 32'hFFFFFFFF, 16'd4};
    tbl[7] = '{0, 32'h00, 32'h0,        0, 5'd0,  32'd0,   1, 0, 32'h00, 0, 5'd0,  32'd0, 16'd4};

    rst_n = 1'b0; trace_en = 0; clr = 0; cpu_pc = 0; cpu_instr = 0;
    cpu_rf_we = 0; cpu_rf_wa = 0; cpu_rf_wd = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.pc", out_pc, 0);
    check("rst.instr", out_instr, 0);
    check("rst.we", out_we, 0);
    check("rst.wa", out_wa, 0);
    check("rst.wd", out_wd, 0);
    check("rst.overflow", overflow, 0);
    check("rst.drop_cnt", drop_cnt, 0);
    check("rst.instr_cnt", instr_cnt, 0);
    check("rst.timeout", timeout, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step("tbl", tbl[i].en, 0, tbl[i].pc, tbl[i].instr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rdy);
      check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d.pc", i), out_pc, tbl[i].epc);
        check($sformatf("tbl%0d.we", i), out_we, tbl[i].ewe);
        check($sformatf("tbl%0d.wa", i), out_wa, tbl[i].ewa);
        check($sformatf("tbl%0d.wd", i), out_wd, tbl[i].ewd);
      end
      check($sformatf("tbl%0d.instr_cnt", i), instr_cnt, tbl[i].eicnt);
    end

    // Overflow: 20 captures into a 16-deep FIFO with no consumer.
    step("clr0", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("fill", 1, 0, 32'(i * 4), 32'h13 + 32'(i), 1, 5'd10, 32'(i), 0);
    check("ovf.overflow", overflow, 1);
    check("ovf.drop_cnt", drop_cnt, 4);
    check("ovf.instr_cnt", instr_cnt, 20);
    check("ovf.head_pc", out_pc, 0);

    // Full with simultaneous pop: push accepted, nothing dropped.
    check("fullpop.pre_pc", out_pc, 32'h00);
    step("fullpop", 1, 0, 32'h40, 32'h13, 1, 5'd10, 32'd99, 1);
    check("fullpop.drop_cnt", drop_cnt, 4);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.pc", i), out_pc, 32'((i + 1) * 4));
      step("drain", 0, 0, 0, 0, 0, 0, 0, 1);
    end
    check("drain.valid_end", out_valid, 0);

    // clr wins over a simultaneous capture and pop.
    step("pre_clr", 1, 0, 32'h100, 32'h13, 1, 5'd1, 32'd7, 0);
    step("clr_prio", 1, 1, 32'h104, 32'h13, 1, 5'd1, 32'd8, 1);
    check("clr.valid", out_valid, 0);
    check("clr.instr_cnt", instr_cnt, 0);
    check("clr.overflow", overflow, 0);

    // Asynchronous reset mid-stream.
    step("pre_rst", 1, 0, 32'h200, 32'h13, 1, 5'd2, 32'd9, 0);
    trace_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", out_valid, 0);
    check("arst.instr_cnt", instr_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised run against the model.
    step("clr1", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 2,
           $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom,
           (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    // Capture limit: 130 enabled cycles with a free-running consumer.
    step("clr2", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 130; i++) begin
      step("to", 1, 0, 32'(i * 4), 32'h13, 1, 5'd10, 32'(i), 1);
`ifdef SR_TRACE_TIMEOUT_EN
      if (i == 119) check("to.at120", timeout, 1);
`endif
    end
    repeat (3) step("to_idle", 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef SR_TRACE_TIMEOUT_EN
    check("to.instr_cnt", instr_cnt, 120);
    check("to.timeout", timeout, 1);
`else
    check("to.instr_cnt", instr_cnt, 130);
    check("to.timeout", timeout, 0);
`endif
    check("to.valid_end", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
